dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the memory end of the CPU load/store port. It accepts one word request at a time over a valid/ready handshake, inserts a programmable number of wait states, and returns read data or a write acknowledgement over a second valid/ready handshake. It replaces the zero-latency data memory when the CPU is moved to a stall-capable datapath, and models slow memory for core verification.

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states between request acceptance and response. Loads return word data.
// Stores apply byte-masked writes. Misaligned or out-of-range accesses report
// resp_err and leave the array untouched.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_leave_resp;
  logic              w_in_idle;
  logic              w_op_write;
  logic [31:0]       w_op_addr;
  logic [31:0]       w_op_wdata;
  logic [3:0]        w_op_wstrb;
  logic              w_op_err;
  logic [AW-1:0]     w_op_idx;

  // Misaligned, or any bit above the index range set (never wrapped).
  function automatic logic addr_error(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
    return m;
  endfunction

  // With zero latency the array is accessed on the accepting edge, so the
  // operands come straight from the request port; otherwise from the latches.
  assign w_in_idle  = (r_state == S_IDLE);
  assign w_op_write = w_in_idle ? req_write : r_write;
  assign w_op_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_op_wdata = w_in_idle ? req_wdata : r_wdata;
  assign w_op_wstrb = w_in_idle ? req_wstrb : r_wstrb;
  assign w_op_err   = addr_error(w_op_addr);
  assign w_op_idx   = w_op_addr[AW+1:2];

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_leave_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          w_accept = 1'b1;
          if (LAT == 4'd0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next       = S_IDLE;
          w_leave_resp = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Wait-state counter, loaded on acceptance and counted down in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_cnt <= 4'd0;
    else if (w_accept)                         r_cnt <= LAT;
    else if (r_state == S_WAIT && r_cnt != 0)  r_cnt <= r_cnt - 4'd1;
  end

  // Request latch; contents only matter between acceptance and RESP entry.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Response data/error: captured entering RESP, cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err   <= w_op_err;
      r_rdata <= (w_op_write || w_op_err) ? 32'd0 : r_mem[w_op_idx];
    end else if (w_leave_resp) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  // Storage array: cleared in reset, byte-masked store committed entering RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
    end else if (w_enter_resp && w_op_write && !w_op_err) begin
      r_mem[w_op_idx] <= merge_bytes(r_mem[w_op_idx], w_op_wdata, w_op_wstrb);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses LATENCY=2, instance B
// uses LATENCY=0; both share clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_wstrb;
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  // Present a request (caller sits 1 time unit after a rising edge with the
  // DUT idle), let it be accepted, then scramble the request bus.
  task automatic send_req(input bit sel, input logic w, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
    if (!sel) begin
      a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_wstrb = st;
    end else begin
      b_req_valid = 1'b1; b_req_write = w; b_req_addr = addr; b_req_wdata = wd; b_req_wstrb = st;
    end
    @(posedge clk); #1;
    if (!sel) begin
      a_req_valid = 1'b0; a_req_write = ~w; a_req_addr = 32'hFFFF_FFF3; a_req_wdata = ~wd; a_req_wstrb = ~st;
    end else begin
      b_req_valid = 1'b0; b_req_write = ~w; b_req_addr = 32'hFFFF_FFF3; b_req_wdata = ~wd; b_req_wstrb = ~st;
    end
  endtask

  // Count cycles from acceptance until resp_valid; 99 means it never came.
  task automatic wait_resp(input bit sel, output int lat, output logic [31:0] rd, output logic er);
    lat = 1;
    while (!(sel ? b_resp_valid : a_resp_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(sel ? b_resp_valid : a_resp_valid)) lat = 99;
    rd = sel ? b_resp_rdata : a_resp_rdata;
    er = sel ? b_resp_err : a_resp_err;
  endtask

  task automatic finish_resp(input bit sel);
    if (!sel) a_resp_ready = 1'b1; else b_resp_ready = 1'b1;
    @(posedge clk); #1;
    if (!sel) a_resp_ready = 1'b0; else b_resp_ready = 1'b0;
  endtask

  task automatic do_txn(input bit sel, input logic w, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int lat, output logic [31:0] rd, output logic er);
    send_req(sel, w, addr, wd, st);
    wait_resp(sel, lat, rd, er);
    finish_resp(sel);
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic er;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", a_req_ready); end
      checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", a_resp_valid); end
      checks++; if (a_resp_rdata !== 32'd0 || a_resp_err !== 1'b0) begin errors++; $display("FAIL rst_outputs got %h/%b exp 0/0", a_resp_rdata, a_resp_err); end
    end
    rst = 1'b1;
    #1;
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready_a got %b exp 1", a_req_ready); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rel_req_ready_b got %b exp 1", b_req_ready); end
    @(posedge clk); #1;
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL rst_load0 got %h/%b exp 00000000/0", rd, er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_load0_lat got %0d exp 3", lat); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL st_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL st_ack got %h/%b exp 00000000/0", rd, er); end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ld_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL ld_data got %h/%b exp deadbeef/0", rd, er); end
  endtask

  task automatic test_strobes();
    int lat; logic [31:0] rd; logic er;
    do_txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, rd, er);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strb_byte0 got %h exp deadbeaa", rd); end
    do_txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    checks++; if (er !== 1'b0 || lat !== 3) begin errors++; $display("FAIL strb_zero_ack got err %b lat %0d exp 0/3", er, lat); end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL strb_zero_data got %h exp deadbeaa", rd); end
    do_txn(0, 1'b1, 32'h10, 32'h11223344, 4'b1010, lat, rd, er);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h11AD33AA) begin errors++; $display("FAIL strb_1010 got %h exp 11ad33aa", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    do_txn(0, 1'b0, 32'h12, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL err_misalign got %h/%b exp 00000000/1", rd, er); end
    do_txn(0, 1'b1, 32'h400, 32'h11223344, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1 || lat !== 3) begin errors++; $display("FAIL err_range_store got err %b lat %0d exp 1/3", er, lat); end
    do_txn(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL err_no_alias got %h/%b exp 00000000/0", rd, er); end
    do_txn(0, 1'b0, 32'h1000_0010, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL err_upper got %h/%b exp 00000000/1", rd, er); end
    do_txn(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, lat, rd, er);
    do_txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL err_last_word got %h/%b exp cafef00d/0", rd, er); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    send_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    wait_resp(0, lat, rd, er);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_lat got %0d exp 3", lat); end
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h3FC;
    repeat (5) begin
      checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h11AD33AA) begin errors++; $display("FAIL bp_hold got %b/%h exp 1/11ad33aa", a_resp_valid, a_resp_rdata); end
      checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready got %b exp 0", a_req_ready); end
      @(posedge clk); #1;
    end
    a_resp_ready = 1'b1;
    #1;
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_hs_ready got %b exp 0", a_req_ready); end
    @(posedge clk); #1;
    a_resp_ready = 1'b0;
    checks++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0) begin errors++; $display("FAIL bp_idle got rdy %b vld %b data %h exp 1/0/0", a_req_ready, a_resp_valid, a_resp_rdata); end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got %b exp 0", a_req_ready); end
    wait_resp(0, lat, rd, er);
    checks++; if (lat !== 3 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_next got lat %0d data %h exp 3/cafef00d", lat, rd); end
    finish_resp(0);
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    send_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
    rst = 1'b0;
    #1;
    checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs got vld %b rdy %b exp 0/0", a_resp_valid, a_req_ready); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", a_resp_valid); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_after got %b exp 0", a_resp_valid); end
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL mid_rst_load20 got %h/%b exp 00000000/0", rd, er); end
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_rst_cleared got %h exp 00000000", rd); end
    // Zero-latency instance: reset while the response is being presented.
    send_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    checks++; if (b_resp_valid !== 1'b1) begin errors++; $display("FAIL l0_resp_valid got %b exp 1", b_resp_valid); end
    rst = 1'b0;
    #1;
    checks++; if (b_resp_valid !== 1'b0 || b_resp_err !== 1'b0) begin errors++; $display("FAIL l0_rst_drop got %b/%b exp 0/0", b_resp_valid, b_resp_err); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL l0_rst_cleared got %h lat %0d exp 0/1", rd, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'h0;
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h0;
    do_txn(1, 1'b1, 32'h4, 32'h11111111, 4'hF, lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL b2b_st_lat got %0d/%b exp 1/0", lat, er); end
    do_txn(1, 1'b1, 32'h8, 32'h22222222, 4'hF, lat, rd, er);
    b_resp_ready = 1'b1;
    b_req_valid  = 1'b1; b_req_write = 1'b0; b_req_addr = addrs[0];
    for (int t = 0; t < 3; t++) begin
      checks++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d got rdy %b vld %b exp 1/0", t, b_req_ready, b_resp_valid); end
      @(posedge clk); #1;
      checks++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== exp_d[t]) begin errors++; $display("FAIL b2b_resp_%0d got %b/%h exp 1/%h", t, b_resp_valid, b_resp_rdata, exp_d[t]); end
      if (t < 2) b_req_addr = addrs[t+1]; else b_req_valid = 1'b0;
      @(posedge clk); #1;
    end
    b_resp_ready = 1'b0;
    checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got vld %b rdy %b exp 0/1", b_resp_valid, b_req_ready); end
  endtask

  initial begin
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_req_wstrb = 4'h0; a_resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_req_wstrb = 4'h0; b_resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_strobes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
